// File: rtl/circular_queue_if.sv
// Producer/consumer bundle for circular_queue: push/pop requests, write data,
// registered read data with its valid strobe, occupancy and sticky error flags.
interface circular_queue_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 10
);
  logic                 Push;
  logic                 Pop;
  logic [DATAWIDTH-1:0] data_i;
  logic [DATAWIDTH-1:0] data_o;
  logic                 valid_o;
  logic                 empty;
  logic                 full;
  logic [ADDRWIDTH:0]   count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output Push, Pop, data_i,
    input  data_o, valid_o, empty, full, count, overflow, underflow
  );

  modport slave (
    input  Push, Pop, data_i,
    output data_o, valid_o, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/circular_queue.sv
// FIFO of 2**ADDRWIDTH words in a register-file RAM with head/tail pointers,
// registered read data plus one-cycle valid strobe, and sticky error flags.
module circular_queue #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 10
) (
  input  logic              Clk,
  input  logic              Rst,
  circular_queue_if.slave   q
);
  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] COUNT_FULL = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH:0] COUNT_ONE  = (ADDRWIDTH+1)'(1);

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic [ADDRWIDTH-1:0] head_q, head_d;
  logic [ADDRWIDTH-1:0] tail_q, tail_d;
  logic [ADDRWIDTH:0]   count_q, count_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic pop_ok;
  logic push_ok;

  // A push into a full queue is still legal when a pop frees the head slot in the same cycle.
  assign pop_ok  = q.Pop & ~empty_q;
  assign push_ok = q.Push & (~full_q | q.Pop);

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (pop_ok) begin
      data_d  = mem[head_q];
      valid_d = 1'b1;
      head_d  = head_q + 1'b1;
    end
    if (push_ok) begin
      tail_d = tail_q + 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase

    if (q.Push & full_q & ~q.Pop) begin
      overflow_d = 1'b1;
    end
    if (q.Pop & empty_q) begin
      underflow_d = 1'b1;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == COUNT_FULL);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // RAM is not reset; the read above sees the pre-edge word, so head==tail while full is safe.
  always_ff @(posedge Clk) begin
    if (!Rst && push_ok) begin
      mem[tail_q] <= q.data_i;
    end
  end

  assign q.data_o    = data_q;
  assign q.valid_o   = valid_q;
  assign q.empty     = empty_q;
  assign q.full      = full_q;
  assign q.count     = count_q;
  assign q.overflow  = overflow_q;
  assign q.underflow = underflow_q;
endmodule

// File: tb/tb_circular_queue.sv
// Self-checking bench for circular_queue: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the FIFO.
module tb_circular_queue;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic Clk = 1'b0;
  logic Rst;

  always #5 Clk = ~Clk;

  circular_queue_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

  circular_queue #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .q   (bus)
  );

  logic [DW-1:0] mq [$];
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  logic          exp_ovf;
  logic          exp_unf;

  int n_vec  = 0;
  int n_miss = 0;

  // One clock of stimulus; the model advances from its own pre-edge occupancy.
  task automatic cycle(input logic rst, input logic push, input logic pop, input logic [DW-1:0] din);
    bit was_empty, was_full, pop_ok, push_ok;
    Rst         = rst;
    bus.Push    = push;
    bus.Pop     = pop;
    bus.data_i  = din;
    @(posedge Clk);
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == DEPTH);
    if (rst) begin
      mq.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      pop_ok    = pop && !was_empty;
      push_ok   = push && (!was_full || pop);
      exp_valid = pop_ok;
      if (pop_ok)  exp_data = mq.pop_front();
      if (push_ok) mq.push_back(din);
      if (push && was_full && !pop) exp_ovf = 1'b1;
      if (pop && was_empty)         exp_unf = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    n_vec++; if (bus.empty !== 1'b1) begin n_miss++; $display("[TB] FAIL reset_empty got %b want 1", bus.empty); end
    n_vec++; if (bus.full !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_full got %b want 0", bus.full); end
    n_vec++; if (bus.count !== '0) begin n_miss++; $display("[TB] FAIL reset_count got %0d want 0", bus.count); end
    n_vec++; if (bus.valid_o !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_valid got %b want 0", bus.valid_o); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_overflow got %b want 0", bus.overflow); end
    n_vec++; if (bus.underflow !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_underflow got %b want 0", bus.underflow); end
    n_vec++; if (bus.data_o !== 8'h00) begin n_miss++; $display("[TB] FAIL reset_data got %h want 00", bus.data_o); end
  endtask

  task automatic test_fifo_order();
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i));
    n_vec++; if (bus.count !== 11'd5) begin n_miss++; $display("[TB] FAIL order_count got %0d want 5", bus.count); end
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      n_vec++; if (bus.valid_o !== 1'b1) begin n_miss++; $display("[TB] FAIL order_valid[%0d] got %b want 1", i, bus.valid_o); end
      n_vec++; if (bus.data_o !== 8'(i)) begin n_miss++; $display("[TB] FAIL order_data[%0d] got %h want %h", i, bus.data_o, 8'(i)); end
    end
    n_vec++; if (bus.empty !== 1'b1) begin n_miss++; $display("[TB] FAIL order_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i & 8'hFF));
    n_vec++; if (bus.full !== 1'b1) begin n_miss++; $display("[TB] FAIL fill_full got %b want 1", bus.full); end
    n_vec++; if (bus.count !== 11'd1024) begin n_miss++; $display("[TB] FAIL fill_count got %0d want 1024", bus.count); end
    cycle(1'b0, 1'b1, 1'b0, 8'hAA);
    n_vec++; if (bus.overflow !== 1'b1) begin n_miss++; $display("[TB] FAIL ovf_flag got %b want 1", bus.overflow); end
    n_vec++; if (bus.count !== 11'd1024) begin n_miss++; $display("[TB] FAIL ovf_count got %0d want 1024", bus.count); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      n_vec++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== 8'(i & 8'hFF)) begin
        n_miss++;
        $display("[TB] FAIL wrap_pop[%0d] got %b/%h want 1/%h", i, bus.valid_o, bus.data_o, 8'(i & 8'hFF));
      end
    end
    n_vec++; if (bus.empty !== 1'b1) begin n_miss++; $display("[TB] FAIL wrap_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_full_pushpop();
    logic [DW-1:0] first_word;
    first_word = 8'($urandom);
    cycle(1'b0, 1'b1, 1'b0, first_word);
    for (int i = 1; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
    cycle(1'b0, 1'b1, 1'b1, 8'h5A);
    n_vec++; if (bus.data_o !== first_word) begin n_miss++; $display("[TB] FAIL fullpp_data got %h want %h", bus.data_o, first_word); end
    n_vec++; if (bus.valid_o !== 1'b1) begin n_miss++; $display("[TB] FAIL fullpp_valid got %b want 1", bus.valid_o); end
    n_vec++; if (bus.count !== 11'd1024) begin n_miss++; $display("[TB] FAIL fullpp_count got %0d want 1024", bus.count); end
    n_vec++; if (bus.full !== 1'b1) begin n_miss++; $display("[TB] FAIL fullpp_full got %b want 1", bus.full); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      n_vec++;
      if (bus.data_o !== exp_data || bus.valid_o !== 1'b1) begin
        n_miss++;
        $display("[TB] FAIL fullpp_drain[%0d] got %b/%h want 1/%h", i, bus.valid_o, bus.data_o, exp_data);
      end
    end
    n_vec++; if (bus.data_o !== 8'h5A) begin n_miss++; $display("[TB] FAIL fullpp_last got %h want 5a", bus.data_o); end
  endtask

  task automatic test_empty_pushpop();
    cycle(1'b0, 1'b1, 1'b1, 8'h33);
    n_vec++; if (bus.underflow !== 1'b1) begin n_miss++; $display("[TB] FAIL emptypp_unf got %b want 1", bus.underflow); end
    n_vec++; if (bus.valid_o !== 1'b0) begin n_miss++; $display("[TB] FAIL emptypp_valid got %b want 0", bus.valid_o); end
    n_vec++; if (bus.count !== 11'd1) begin n_miss++; $display("[TB] FAIL emptypp_count got %0d want 1", bus.count); end
    n_vec++; if (bus.data_o !== 8'h5A) begin n_miss++; $display("[TB] FAIL emptypp_hold got %h want 5a", bus.data_o); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    n_vec++; if (bus.data_o !== 8'h33 || bus.valid_o !== 1'b1) begin n_miss++; $display("[TB] FAIL emptypp_pop got %b/%h want 1/33", bus.valid_o, bus.data_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    n_vec++; if (bus.count !== '0) begin n_miss++; $display("[TB] FAIL rstmid_count got %0d want 0", bus.count); end
    n_vec++; if (bus.empty !== 1'b1) begin n_miss++; $display("[TB] FAIL rstmid_empty got %b want 1", bus.empty); end
    n_vec++; if (bus.valid_o !== 1'b0) begin n_miss++; $display("[TB] FAIL rstmid_valid got %b want 0", bus.valid_o); end
    n_vec++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_miss++; $display("[TB] FAIL rstmid_flags got %b%b want 00", bus.overflow, bus.underflow); end
    cycle(1'b0, 1'b1, 1'b0, 8'h77);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    n_vec++; if (bus.data_o !== 8'h77 || bus.valid_o !== 1'b1) begin n_miss++; $display("[TB] FAIL rstmid_pop got %b/%h want 1/77", bus.valid_o, bus.data_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 199) == 0), $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom));
      n_vec++;
      if (bus.data_o !== exp_data || bus.valid_o !== exp_valid ||
          bus.count !== (AW+1)'(mq.size()) || bus.empty !== (mq.size() == 0) ||
          bus.full !== (mq.size() == DEPTH) || bus.overflow !== exp_ovf || bus.underflow !== exp_unf) begin
        n_miss++;
        $display("[TB] FAIL rand[%0d] got d=%h v=%b c=%0d e=%b f=%b o=%b u=%b want d=%h v=%b c=%0d o=%b u=%b",
                 i, bus.data_o, bus.valid_o, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow,
                 exp_data, exp_valid, mq.size(), exp_ovf, exp_unf);
      end
    end
  endtask

  initial begin
    Rst        = 1'b1;
    bus.Push   = 1'b0;
    bus.Pop    = 1'b0;
    bus.data_i = '0;
    exp_data   = '0;
    exp_valid  = 1'b0;
    exp_ovf    = 1'b0;
    exp_unf    = 1'b0;
    test_reset();
    test_fifo_order();
    test_fill_wrap();
    test_full_pushpop();
    test_empty_pushpop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
